fir_channel_scheduler: RTL and testbench

- Time-shares one FIR MAC engine (controller plus datapath) among N_CH independent sample channels.
- Each channel has a one-entry input holding register. The scheduler picks the next pending channel round-robin, issues a start pulse to the engine with the sample and channel index, waits for the engine's done pulse, and presents the result on a valid/ready output port.
- Sits between the per-channel sample sources and the FIR engine. The engine keeps a delay-line bank per channel, selected by eng_ch.

---
 rtl/fir_channel_scheduler_pkg.sv | 20 ++
 rtl/fir_channel_scheduler_arb.sv | 32 +++
 rtl/fir_channel_scheduler.sv | 158 +++++++++++++++
 tb/tb_fir_channel_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_channel_scheduler_pkg.sv
// Shared types and defaults for the FIR channel scheduler.
package fir_sched_pkg;

  localparam int unsigned DEF_N_CH           = 4;
  localparam int unsigned DEF_DATA_W         = 8;
  localparam int unsigned DEF_RES_W          = 20;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } sched_state_e;

  function automatic int unsigned ch_width(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/fir_channel_scheduler_arb.sv
// Combinational round-robin picker: first set bit of pending_i at or above rr_ptr_i, with wrap.
module fir_rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter int unsigned N_CH = DEF_N_CH,
  parameter int unsigned CH_W = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] pending_i,
  input  logic [CH_W-1:0] rr_ptr_i,
  output logic            any_o,
  output logic [CH_W-1:0] grant_o
);

  logic [CH_W:0] idx;

  always_comb begin
    any_o   = 1'b0;
    grant_o = '0;
    idx     = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = {1'b0, rr_ptr_i} + (CH_W+1)'(i);
      if (idx >= (CH_W+1)'(N_CH)) begin
        idx = idx - (CH_W+1)'(N_CH);
      end
      if (!any_o && pending_i[idx[CH_W-1:0]]) begin
        any_o   = 1'b1;
        grant_o = idx[CH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Round-robin time-sharing of one FIR MAC engine across N_CH sample channels.
// Optional watchdog on the engine wait enabled by `define FIR_SCHED_TIMEOUT_EN.
module fir_channel_scheduler
  import fir_sched_pkg::*;
#(
  parameter  int unsigned N_CH           = DEF_N_CH,
  parameter  int unsigned DATA_W         = DEF_DATA_W,
  parameter  int unsigned RES_W          = DEF_RES_W,
  parameter  int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int unsigned CH_W           = ch_width(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  output logic [N_CH-1:0]          in_ready,
  output logic                     eng_start,
  output logic [CH_W-1:0]          eng_ch,
  output logic [DATA_W-1:0]        eng_data,
  input  logic                     eng_done,
  input  logic [RES_W-1:0]         eng_result,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic [RES_W-1:0]         out_data,
  input  logic                     out_ready,
  output logic                     err
);

  sched_state_e                   state_q, state_d;
  logic [N_CH-1:0]                pending_q, pending_d, accept;
  logic [N_CH-1:0][DATA_W-1:0]    hold_q, hold_d;
  logic [CH_W-1:0]                rr_ptr_q, rr_ptr_d, grant_q;
  logic [DATA_W-1:0]              eng_data_q;
  logic [CH_W-1:0]                out_ch_q;
  logic [RES_W-1:0]               out_data_q;
  logic                           arb_any;
  logic [CH_W-1:0]                arb_grant;
  logic                           tmo_hit;
  logic                           job_end;

  fir_rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .pending_i (pending_q),
    .rr_ptr_i  (rr_ptr_q),
    .any_o     (arb_any),
    .grant_o   (arb_grant)
  );

  assign accept = in_valid & ~pending_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_hold
    assign hold_d[g] = accept[g] ? in_data[g*DATA_W +: DATA_W] : hold_q[g];
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // eng_done wins over a same-cycle timeout so a late result is never lost
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (eng_done) state_d = DRAIN;
               else if (tmo_hit) state_d = IDLE;
      DRAIN:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    eng_start = (state_q == ISSUE);
    out_valid = (state_q == DRAIN);
  end

  assign job_end = ((state_q == DRAIN) && out_ready) ||
                   ((state_q == WAIT) && !eng_done && tmo_hit);

  always_comb begin
    pending_d = pending_q | accept;
    if (state_q == ISSUE) begin
      pending_d[grant_q] = 1'b0;
    end
    rr_ptr_d = rr_ptr_q;
    if (job_end) begin
      rr_ptr_d = (grant_q == CH_W'(N_CH - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      eng_data_q <= '0;
      out_ch_q   <= '0;
      out_data_q <= '0;
    end else begin
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      if ((state_q == IDLE) && arb_any) begin
        grant_q    <= arb_grant;
        eng_data_q <= hold_q[arb_grant];
      end
      if ((state_q == WAIT) && eng_done) begin
        out_ch_q   <= grant_q;
        out_data_q <= eng_result;
      end
    end
  end

  assign in_ready = ~pending_q;
  assign eng_ch   = grant_q;
  assign eng_data = eng_data_q;
  assign out_ch   = out_ch_q;
  assign out_data = out_data_q;

`ifdef FIR_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             err_q;

  // counter sits at zero outside WAIT, so it is always fresh on entry
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= (state_q == WAIT) ? tmo_q + 1'b1 : '0;
      if ((state_q == WAIT) && !eng_done && tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign tmo_hit = (state_q == WAIT) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;
`else
  logic [31:0] unused_tmo;

  assign unused_tmo = 32'(TIMEOUT_CYCLES);
  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Scoreboard bench for fir_channel_scheduler with a behavioural FIR engine model.
module tb_fir_channel_scheduler;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int RW  = 20;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      in_valid = '0;
  logic [N*DW-1:0]   in_data = '0;
  logic [N-1:0]      in_ready;
  logic              eng_start;
  logic [1:0]        eng_ch;
  logic [DW-1:0]     eng_data;
  logic              eng_done = 1'b0;
  logic [RW-1:0]     eng_result = '0;
  logic              out_valid;
  logic [1:0]        out_ch;
  logic [RW-1:0]     out_data;
  logic              out_ready = 1'b1;
  logic              err;

  fir_channel_scheduler #(
    .N_CH           (N),
    .DATA_W         (DW),
    .RES_W          (RW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .eng_start  (eng_start),
    .eng_ch     (eng_ch),
    .eng_data   (eng_data),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] res_fn(input logic [1:0] ch, input logic [DW-1:0] d);
    return {2'b01, ch, 8'h00, d} ^ 20'h0A5A0;
  endfunction

  // when: >=0 absolute start cycle, -1 unchecked, -2 last drain + 2, -3 last start + TMO + 2
  typedef struct { logic [1:0] ch; logic [DW-1:0] data; int when; } iss_t;
  typedef struct { logic [1:0] ch; logic [RW-1:0] res; } res_t;

  iss_t iq[$];
  res_t oq[$];

  task automatic push_job(input logic [1:0] ch, input logic [DW-1:0] d, input int when,
                          input bit has_out, input logic [RW-1:0] res);
    iss_t e;
    res_t r;
    e.ch = ch; e.data = d; e.when = when;
    iq.push_back(e);
    if (has_out) begin
      r.ch = ch; r.res = res;
      oq.push_back(r);
    end
  endtask

  // engine model: done eng_delay cycles after start, unless hung
  int            eng_delay = 5;
  bit            eng_hang  = 1'b0;
  bit            fix_en    = 1'b0;
  logic [RW-1:0] fix_val   = '0;
  bit            busy      = 1'b0;
  int            ecnt      = 0;
  logic [1:0]    lch;
  logic [DW-1:0] ldata;

  always @(posedge clk) begin
    #2;
    if (rst) begin
      eng_done = 1'b0;
      busy     = 1'b0;
    end else begin
      eng_done = 1'b0;
      if (eng_start) begin
        busy  = 1'b1;
        ecnt  = eng_delay;
        lch   = eng_ch;
        ldata = eng_data;
      end else if (busy && !eng_hang) begin
        if (ecnt <= 1) begin
          eng_done   = 1'b1;
          eng_result = fix_en ? fix_val : res_fn(lch, ldata);
          busy       = 1'b0;
        end else begin
          ecnt--;
        end
      end
    end
  end

  int last_start = -100;
  int last_done  = -100;
  int last_drain = -100;
  bit prev_ov    = 1'b0;

  always @(negedge clk) begin
    iss_t e;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (eng_start) begin
        if (iq.size() == 0) begin
          check("unexp_start", 32'(eng_ch), 32'hFFFF_FFFF);
        end else begin
          e = iq.pop_front();
          check("eng_ch", 32'(eng_ch), 32'(e.ch));
          check("eng_data", 32'(eng_data), 32'(e.data));
          if (e.when >= 0)       check("start_lat", 32'(cyc), 32'(e.when));
          else if (e.when == -2) check("b2b_lat", 32'(cyc), 32'(last_drain + 2));
          else if (e.when == -3) check("tmo_next", 32'(cyc), 32'(last_start + TMO + 2));
        end
        last_start = cyc;
      end
      if (eng_done) last_done = cyc;
      if (out_valid) begin
        if (!prev_ov) check("out_lat", 32'(cyc), 32'(last_done + 1));
        if (oq.size() == 0) begin
          check("unexp_out", 32'(out_ch), 32'hFFFF_FFFF);
        end else begin
          check("out_ch", 32'(out_ch), 32'(oq[0].ch));
          check("out_data", 32'(out_data), 32'(oq[0].res));
          if (out_ready) begin
            void'(oq.pop_front());
            last_drain = cyc;
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_mask(input logic [N-1:0] m, input logic [N*DW-1:0] d, output int t);
    logic [N-1:0] rem;
    int n;
    rem = m;
    n = 0;
    t = -1;
    tick();
    in_data = d;
    while (rem != '0 && n < 100) begin
      in_valid = rem;
      if ((rem & in_ready) != '0) t = cyc;
      rem = rem & ~in_ready;
      tick();
      n++;
    end
    in_valid = '0;
    if (rem != '0) check("accept_timeout", 32'(rem), 32'h0);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (iq.size() == 0 && oq.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'(iq.size() + oq.size()), 32'h0);
    tick();
    tick();
  endtask

  task automatic do_reset(input string tag);
    tick();
    rst = 1'b1;
    iq.delete();
    oq.delete();
    tick();
    rst = 1'b0;
    check({tag, "_start"}, 32'(eng_start), 32'h0);
    check({tag, "_ch"}, 32'(eng_ch), 32'h0);
    check({tag, "_data"}, 32'(eng_data), 32'h0);
    check({tag, "_oval"}, 32'(out_valid), 32'h0);
    check({tag, "_och"}, 32'(out_ch), 32'h0);
    check({tag, "_odata"}, 32'(out_data), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_rdy"}, 32'(in_ready), 32'hF);
  endtask

  initial begin
    int t;
    int acc;
    bit exp_rdy, nxt;
    bit seen;

    repeat (3) tick();
    do_reset("rst0");

    // single sample on ch2 with a fixed engine result
    fix_en = 1'b1;
    fix_val = 20'h00ABC;
    send_mask(4'b0100, 32'h007F_0000, t);
    push_job(2'd2, 8'h7F, t + 2, 1'b1, 20'h00ABC);
    wait_idle();
    fix_en = 1'b0;

    // all four at once, then ch0 refills and is served after ch3
    do_reset("rst1");
    send_mask(4'b1111, 32'h4433_2211, t);
    push_job(2'd0, 8'h11, t + 2, 1'b1, res_fn(2'd0, 8'h11));
    push_job(2'd1, 8'h22, -2, 1'b1, res_fn(2'd1, 8'h22));
    push_job(2'd2, 8'h33, -2, 1'b1, res_fn(2'd2, 8'h33));
    push_job(2'd3, 8'h44, -2, 1'b1, res_fn(2'd3, 8'h44));
    send_mask(4'b0001, 32'h0000_0055, t);
    push_job(2'd0, 8'h55, -2, 1'b1, res_fn(2'd0, 8'h55));
    wait_idle();

    // backpressure with a second job waiting behind it
    out_ready = 1'b0;
    send_mask(4'b0010, 32'h0000_6600, t);
    push_job(2'd1, 8'h66, t + 2, 1'b1, res_fn(2'd1, 8'h66));
    send_mask(4'b0100, 32'h0077_0000, t);
    push_job(2'd2, 8'h77, -2, 1'b1, res_fn(2'd2, 8'h77));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_seen", 32'(seen), 32'h1);
    for (int i = 0; i < 10; i++) begin
      check("bp_nostart", 32'(eng_start), 32'h0);
      check("bp_valid", 32'(out_valid), 32'h1);
      tick();
    end
    out_ready = 1'b1;
    wait_idle();

    // ch0 held valid continuously: one accept per job
    exp_rdy = 1'b1;
    acc = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      in_valid[0] = 1'b1;
      in_data[7:0] = 8'(8'hA0 + acc);
      check("hold_rdy", 32'(in_ready[0]), 32'(exp_rdy));
      nxt = exp_rdy;
      if (in_ready[0]) begin
        push_job(2'd0, 8'(8'hA0 + acc), (acc == 0) ? cyc + 2 : -2, 1'b1,
                 res_fn(2'd0, 8'(8'hA0 + acc)));
        acc++;
        nxt = 1'b0;
      end
      if (eng_start && eng_ch == 2'd0) nxt = 1'b1;
      exp_rdy = nxt;
      if (acc == 3) break;
    end
    tick();
    in_valid = '0;
    check("hold_accepts", 32'(acc), 32'h3);
    wait_idle();

    // reset while the engine is busy
    eng_delay = 30;
    send_mask(4'b0100, 32'h0033_0000, t);
    push_job(2'd2, 8'h33, t + 2, 1'b1, res_fn(2'd2, 8'h33));
    send_mask(4'b1000, 32'h4400_0000, t);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (iq.size() == 0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("mid_started", 32'(seen), 32'h1);
    repeat (3) tick();
    check("pend_pre", 32'(in_ready[3]), 32'h0);
    do_reset("rst2");
    eng_delay = 5;
    send_mask(4'b1001, 32'h9900_0088, t);
    push_job(2'd0, 8'h88, t + 2, 1'b1, res_fn(2'd0, 8'h88));
    push_job(2'd3, 8'h99, -2, 1'b1, res_fn(2'd3, 8'h99));
    wait_idle();

`ifdef FIR_SCHED_TIMEOUT_EN
    // engine hangs on ch1; watchdog drops it and ch2 proceeds
    eng_hang = 1'b1;
    send_mask(4'b0110, 32'h00CC_BB00, t);
    push_job(2'd1, 8'hBB, t + 2, 1'b0, '0);
    push_job(2'd2, 8'hCC, -3, 1'b1, res_fn(2'd2, 8'hCC));
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (err) begin
        seen = 1'b1;
        break;
      end
    end
    check("tmo_err", 32'(seen), 32'h1);
    check("tmo_lat", 32'(cyc), 32'(last_start + TMO + 1));
    eng_hang = 1'b0;
    wait_idle();
    check("err_sticky", 32'(err), 32'h1);
`else
    check("err_tied", 32'(err), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before 1 ms");
    $fatal(1, "bench watchdog expired");
  end

endmodule
